// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init, then auto-refresh > write > read grants.
// Optional ARBIT_CMD_REG_EN registers the muxed SDRAM bus by one cycle.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111,
  parameter int         ADDR_W  = 13
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  output logic              ref_en,
  input  logic              flag_ref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_ba,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_ba,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_bank
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t state;

  // Grants are only taken from ARBIT, so a finished owner always
  // spends one idle cycle there before the next grant.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state  <= INIT;
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      unique case (state)
        INIT: begin
          if (flag_init_end)
            state <= ARBIT;
        end
        ARBIT: begin
          priority case (1'b1)
            ref_req: begin
              state  <= AREF;
              ref_en <= 1'b1;
            end
            wr_req: begin
              state <= WRITE;
              wr_en <= 1'b1;
            end
            rd_req: begin
              state <= READ;
              rd_en <= 1'b1;
            end
            default: state <= ARBIT;
          endcase
        end
        AREF: begin
          if (flag_ref_end)
            state <= ARBIT;
        end
        WRITE: begin
          if (flag_wr_end)
            state <= ARBIT;
        end
        READ: begin
          if (flag_rd_end)
            state <= ARBIT;
        end
        default: state <= INIT;
      endcase
    end
  end

  logic [3:0]        mux_cmd;
  logic [ADDR_W-1:0] mux_addr;
  logic [1:0]        mux_bank;

  always_comb begin
    mux_cmd  = CMD_NOP;
    mux_addr = '0;
    mux_bank = 2'b00;
    unique case (state)
      INIT: begin
        mux_cmd  = init_cmd;
        mux_addr = init_addr;
      end
      AREF: begin
        mux_cmd  = aref_cmd;
        mux_addr = ref_addr;
      end
      WRITE: begin
        mux_cmd  = wr_cmd;
        mux_addr = wr_addr;
        mux_bank = wr_ba;
      end
      READ: begin
        mux_cmd  = rd_cmd;
        mux_addr = rd_addr;
        mux_bank = rd_ba;
      end
      default: begin
        mux_cmd  = CMD_NOP;
        mux_addr = '0;
        mux_bank = 2'b00;
      end
    endcase
  end

`ifdef ARBIT_CMD_REG_EN
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_bank <= 2'b00;
    end else begin
      sdram_cmd  <= mux_cmd;
      sdram_addr <= mux_addr;
      sdram_bank <= mux_bank;
    end
  end
`else
  assign sdram_cmd  = mux_cmd;
  assign sdram_addr = mux_addr;
  assign sdram_bank = mux_bank;
`endif

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus random traffic
// compared cycle by cycle against an ownership model.
module tb_sdram_arbit;

  localparam logic [3:0] NOP = 4'b0111;
  localparam int         AW  = 13;

  logic          sclk = 1'b0;
  logic          s_rst;
  logic          flag_init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          ref_req, ref_en, flag_ref_end;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] ref_addr;
  logic          wr_req, wr_en, flag_wr_end;
  logic [3:0]    wr_cmd;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_ba;
  logic          rd_req, rd_en, flag_rd_end;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_ba;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [1:0]    sdram_bank;

  always #5 sclk = ~sclk;

  sdram_arbit #(.CMD_NOP(NOP), .ADDR_W(AW)) dut (
    .sclk(sclk), .s_rst(s_rst), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Who owns the bus, and which grant pulse is visible now.
  typedef enum int {O_INIT, O_IDLE, O_REF, O_WR, O_RD} own_t;
  own_t          own = O_INIT;
  logic          m_ref = 1'b0, m_wr = 1'b0, m_rd = 1'b0;
  logic [3:0]    mq_cmd = NOP;
  logic [AW-1:0] mq_addr = '0;
  logic [1:0]    mq_ba = 2'b00;
  logic [3:0]    t_cmd;
  logic [AW-1:0] t_addr;
  logic [1:0]    t_ba;

  task automatic bus_of(input own_t o, output logic [3:0] c,
                        output logic [AW-1:0] a, output logic [1:0] b);
    c = NOP; a = '0; b = 2'b00;
    if (o == O_INIT) begin c = init_cmd; a = init_addr; end
    if (o == O_REF)  begin c = aref_cmd; a = ref_addr;  end
    if (o == O_WR)   begin c = wr_cmd; a = wr_addr; b = wr_ba; end
    if (o == O_RD)   begin c = rd_cmd; a = rd_addr; b = rd_ba; end
  endtask

  always @(posedge sclk) begin
    bus_of(own, t_cmd, t_addr, t_ba);
    mq_cmd  = s_rst ? NOP : t_cmd;
    mq_addr = s_rst ? '0 : t_addr;
    mq_ba   = s_rst ? 2'b00 : t_ba;
    m_ref = 1'b0; m_wr = 1'b0; m_rd = 1'b0;
    if (s_rst) own = O_INIT;
    else if (own == O_INIT && flag_init_end) own = O_IDLE;
    else if (own == O_IDLE) begin
      if (ref_req)     begin own = O_REF; m_ref = 1'b1; end
      else if (wr_req) begin own = O_WR;  m_wr = 1'b1;  end
      else if (rd_req) begin own = O_RD;  m_rd = 1'b1;  end
    end
    else if (own == O_REF && flag_ref_end) own = O_IDLE;
    else if (own == O_WR && flag_wr_end)   own = O_IDLE;
    else if (own == O_RD && flag_rd_end)   own = O_IDLE;
  end

  logic [3:0]    e_cmd;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_ba;

  initial begin
    @(posedge sclk);
    forever begin
      @(negedge sclk);
`ifdef ARBIT_CMD_REG_EN
      e_cmd = mq_cmd; e_addr = mq_addr; e_ba = mq_ba;
`else
      bus_of(own, e_cmd, e_addr, e_ba);
`endif
      chk("cycle",
          {10'd0, ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank},
          {10'd0, m_ref, m_wr, m_rd, e_cmd, e_addr, e_ba});
    end
  end

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

`ifdef ARBIT_CMD_REG_EN
  localparam logic [3:0] RST_CMD = NOP;
`else
  localparam logic [3:0] RST_CMD = 4'b0001;
`endif

  initial begin
    s_rst = 1'b1; flag_init_end = 1'b0;
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    init_cmd = 4'b0001; init_addr = 13'h0400;
    aref_cmd = 4'b0001; ref_addr = 13'h1abc;
    wr_cmd = 4'b0100; wr_addr = 13'h0123; wr_ba = 2'b10;
    rd_cmd = 4'b0101; rd_addr = 13'h0456; rd_ba = 2'b01;
    repeat (2) step();
    s_rst = 1'b0;
    repeat (10) step();
    chk("init_cmd", 32'(sdram_cmd), 32'h1);
    chk("init_addr", 32'(sdram_addr), 32'h400);
    chk("init_bank", 32'(sdram_bank), 32'h0);
    chk("init_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_init_end = 1'b1;
    step();
`ifdef ARBIT_CMD_REG_EN
    step();
`endif
    chk("arbit_cmd", 32'(sdram_cmd), 32'h7);
    chk("arbit_addr", 32'(sdram_addr), 32'h0);
    flag_init_end = 1'b0;
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk("grant_all", {29'd0, ref_en, wr_en, rd_en}, 32'h4);
    ref_req = 1'b0; flag_wr_end = 1'b1;
    step();
    chk("stray_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    chk("aref_cmd", 32'(sdram_cmd), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h1abc);
    flag_wr_end = 1'b0; flag_ref_end = 1'b1;
    step();
    chk("gap_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_ref_end = 1'b0;
    step();
    chk("wr_grant", {29'd0, ref_en, wr_en, rd_en}, 32'h2);
    wr_req = 1'b0;
    step();
    chk("wr_hold_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    chk("wr_cmd", 32'(sdram_cmd), 32'h4);
    chk("wr_addr", 32'(sdram_addr), 32'h123);
    chk("wr_bank", 32'(sdram_bank), 32'h2);
    s_rst = 1'b1;
    step();
    chk("rst_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    chk("rst_cmd", 32'(sdram_cmd), 32'(RST_CMD));
    s_rst = 1'b0;
    step();
    chk("rst_hold_cmd", 32'(sdram_cmd), 32'h1);
    chk("rst_hold_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_init_end = 1'b1;
    step();
    chk("reinit_en", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_init_end = 1'b0;
    step();
    chk("rd_grant", {29'd0, ref_en, wr_en, rd_en}, 32'h1);
    rd_req = 1'b0; ref_req = 1'b1;
    step();
    chk("mid_rd1", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    step();
    chk("mid_rd2", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_rd_end = 1'b1;
    step();
    chk("rd_gap", {29'd0, ref_en, wr_en, rd_en}, 32'h0);
    flag_rd_end = 1'b0;
    step();
    chk("ref_after_rd", {29'd0, ref_en, wr_en, rd_en}, 32'h4);
    ref_req = 1'b0; flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      step();
      if (m_ref) ref_req = 1'b0;
      else if (!ref_req) ref_req = ($urandom_range(0, 5) == 0);
      if (m_wr) wr_req = 1'b0;
      else if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
      if (m_rd) rd_req = 1'b0;
      else if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
      flag_init_end = ($urandom_range(0, 3) == 0);
      flag_ref_end  = ($urandom_range(0, 3) == 0);
      flag_wr_end   = ($urandom_range(0, 3) == 0);
      flag_rd_end   = ($urandom_range(0, 3) == 0);
      s_rst         = ($urandom_range(0, 59) == 0);
      init_cmd  = 4'($urandom);  init_addr = AW'($urandom);
      aref_cmd  = 4'($urandom);  ref_addr  = AW'($urandom);
      wr_cmd    = 4'($urandom);  wr_addr   = AW'($urandom);
      wr_ba     = 2'($urandom);
      rd_cmd    = 4'($urandom);  rd_addr   = AW'($urandom);
      rd_ba     = 2'($urandom);
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
